// File: rtl/rob_retire_pkg.sv
// Shared types and widths for the reorder buffer and its retire selector.
// SUPERSCALAR_WAYS sets the default machine width; ROB_HALT_RETIRE_EN is used by the other files.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package rob_retire_pkg;

    localparam int unsigned ROB_DEPTH_DEF = 32;
    localparam int unsigned ROB_IDX_BITS  = $clog2(ROB_DEPTH_DEF);
    localparam int unsigned ROB_CNT_BITS  = $clog2(ROB_DEPTH_DEF + 1);
    localparam int unsigned WAYS_DEFAULT  = `SUPERSCALAR_WAYS;
    localparam int unsigned AR_IDX_BITS   = 5;
    localparam int unsigned PR_IDX_BITS   = 6;

    typedef struct packed {
        logic                   valid;
        logic [AR_IDX_BITS-1:0] ar_idx;
        logic [PR_IDX_BITS-1:0] t_idx;
        logic [PR_IDX_BITS-1:0] told_idx;
        logic                   halt;
    } ROB_DISPATCH_PACKET;

    typedef struct packed {
        logic                    valid;
        logic [ROB_IDX_BITS-1:0] rob_idx;
        logic                    mispredict;
    } ROB_COMPLETE_PACKET;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   mispredict;
        logic [AR_IDX_BITS-1:0] ar_idx;
        logic [PR_IDX_BITS-1:0] t_idx;
        logic [PR_IDX_BITS-1:0] told_idx;
        logic                   halt;
    } ROB_ENTRY;

    typedef struct packed {
        logic                   complete;
        logic [AR_IDX_BITS-1:0] ar_idx;
        logic [PR_IDX_BITS-1:0] t_idx;
        logic [PR_IDX_BITS-1:0] told_idx;
    } RETIRE_PACKET;

endpackage

// File: rtl/rob_retire_select.sv
// Combinational in-order retire eligibility over the WAYS oldest ROB entries.
// With ROB_HALT_RETIRE_EN defined, a retiring halt entry closes the retire group.
module rob_retire_select
    import rob_retire_pkg::*;
#(
    parameter int unsigned WAYS = WAYS_DEFAULT
) (
    input  ROB_ENTRY [WAYS-1:0]          i_window,
    input  logic                         i_halted,
    output logic [WAYS-1:0]              o_retire_mask,
    output logic [$clog2(WAYS+1)-1:0]    o_retire_cnt,
    output logic                         o_squash,
    output logic                         o_halt
);

    localparam int unsigned RCNT_BITS = $clog2(WAYS + 1);

    logic w_open;

    always_comb begin
        o_retire_mask = '0;
        o_retire_cnt  = '0;
        o_squash      = 1'b0;
        o_halt        = 1'b0;
        w_open        = ~i_halted;
        for (int k = 0; k < WAYS; k++) begin
            if (w_open && i_window[k].valid && i_window[k].done) begin
                o_retire_mask[k] = 1'b1;
                o_retire_cnt     = o_retire_cnt + RCNT_BITS'(1);
                // A mispredict always ends the group, so it can only sit on the youngest lane.
                o_squash         = i_window[k].mispredict;
                if (i_window[k].mispredict) begin
                    w_open = 1'b0;
                end
`ifdef ROB_HALT_RETIRE_EN
                if (i_window[k].halt) begin
                    o_halt = 1'b1;
                    w_open = 1'b0;
                end
`endif
            end else begin
                w_open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: circular dispatch, CDB completion, in-order retire and squash on mispredict.
// Optional ROB_HALT_RETIRE_EN makes a retiring halt entry stop all later retirement.
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned WAYS      = WAYS_DEFAULT
) (
    input  logic                                clock,
    input  logic                                reset,
    input  ROB_DISPATCH_PACKET [WAYS-1:0]       dispatch_in,
    input  ROB_COMPLETE_PACKET [WAYS-1:0]       complete_in,
    output logic [WAYS-1:0][ROB_IDX_BITS-1:0]   rob_tail_idx,
    output logic [ROB_CNT_BITS-1:0]             rob_free_slots,
    output RETIRE_PACKET [WAYS-1:0]             retire_out,
    output logic                                squash_out,
    output logic                                halt_out
);

    localparam int unsigned WCNT_BITS = $clog2(WAYS + 1);

    ROB_ENTRY                r_entries [ROB_DEPTH];
    logic [ROB_IDX_BITS-1:0] r_head;
    logic [ROB_IDX_BITS-1:0] r_tail;
    logic [ROB_CNT_BITS-1:0] r_count;

    ROB_ENTRY                w_entries_nxt [ROB_DEPTH];
    ROB_ENTRY [WAYS-1:0]     w_window;
    logic [WAYS-1:0]         w_retire_mask;
    logic [WCNT_BITS-1:0]    w_retire_cnt;
    logic [WCNT_BITS-1:0]    w_disp_cnt;
    logic [WCNT_BITS-1:0]    w_disp_req;
    logic                    w_squash;
    logic                    w_halt;
    logic                    w_halted;
    logic [ROB_IDX_BITS-1:0] w_head_nxt;
    logic [ROB_IDX_BITS-1:0] w_tail_nxt;
    logic [ROB_CNT_BITS-1:0] w_count_nxt;

    assign rob_free_slots = ROB_CNT_BITS'(ROB_DEPTH) - r_count;

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            w_window[k]     = r_entries[r_head + ROB_IDX_BITS'(k)];
            rob_tail_idx[k] = r_tail + ROB_IDX_BITS'(k);
        end
    end

    rob_retire_select #(
        .WAYS (WAYS)
    ) u_select (
        .i_window      (w_window),
        .i_halted      (w_halted),
        .o_retire_mask (w_retire_mask),
        .o_retire_cnt  (w_retire_cnt),
        .o_squash      (w_squash),
        .o_halt        (w_halt)
    );

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            retire_out[k] = '0;
            if (w_retire_mask[k]) begin
                retire_out[k].complete = 1'b1;
                retire_out[k].ar_idx   = w_window[k].ar_idx;
                retire_out[k].t_idx    = w_window[k].t_idx;
                retire_out[k].told_idx = w_window[k].told_idx;
            end
        end
    end

    assign squash_out = w_squash;
    assign halt_out   = w_halt;

    always_comb begin
        w_disp_req = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (dispatch_in[k].valid) begin
                w_disp_req = w_disp_req + WCNT_BITS'(1);
            end
        end
    end

    // Order matters: completes, then retire clears, then dispatch writes into free slots.
    always_comb begin
        w_entries_nxt = r_entries;
        w_disp_cnt    = '0;
        if (!w_squash) begin
            for (int k = 0; k < WAYS; k++) begin
                if (complete_in[k].valid && r_entries[complete_in[k].rob_idx].valid) begin
                    w_entries_nxt[complete_in[k].rob_idx].done       = 1'b1;
                    w_entries_nxt[complete_in[k].rob_idx].mispredict = complete_in[k].mispredict;
                end
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (w_retire_mask[k]) begin
                w_entries_nxt[r_head + ROB_IDX_BITS'(k)].valid = 1'b0;
            end
        end
        if (!w_squash) begin
            for (int k = 0; k < WAYS; k++) begin
                if (dispatch_in[k].valid && (ROB_CNT_BITS'(k) < rob_free_slots)) begin
                    w_entries_nxt[r_tail + ROB_IDX_BITS'(k)] = '{
                        valid:      1'b1,
                        done:       1'b0,
                        mispredict: 1'b0,
                        ar_idx:     dispatch_in[k].ar_idx,
                        t_idx:      dispatch_in[k].t_idx,
                        told_idx:   dispatch_in[k].told_idx,
                        halt:       dispatch_in[k].halt
                    };
                    w_disp_cnt = w_disp_cnt + WCNT_BITS'(1);
                end
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                w_entries_nxt[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        w_head_nxt = r_head + ROB_IDX_BITS'(w_retire_cnt);
        if (w_squash) begin
            w_tail_nxt  = w_head_nxt;
            w_count_nxt = '0;
        end else begin
            w_tail_nxt  = r_tail + ROB_IDX_BITS'(w_disp_cnt);
            w_count_nxt = r_count + ROB_CNT_BITS'(w_disp_cnt) - ROB_CNT_BITS'(w_retire_cnt);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_entries <= w_entries_nxt;
        end
    end

`ifdef ROB_HALT_RETIRE_EN
    logic r_halted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halted <= 1'b0;
        end else if (w_halt) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && !w_squash) begin
            assert (ROB_CNT_BITS'(w_disp_req) <= rob_free_slots)
            else $warning("rob_retire: %0d dispatch lanes exceed %0d free slots, excess dropped",
                          w_disp_req, rob_free_slots);
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: reset, in-order retire, full, wrap, squash and halt handling.
// Build with +define+ROB_HALT_RETIRE_EN to exercise the halt-stop behaviour.
module tb_rob_retire;
    import rob_retire_pkg::*;

    localparam int unsigned WAYS = WAYS_DEFAULT;

    logic                               clock = 1'b0;
    logic                               reset = 1'b0;
    ROB_DISPATCH_PACKET [WAYS-1:0]      dispatch_in;
    ROB_COMPLETE_PACKET [WAYS-1:0]      complete_in;
    logic [WAYS-1:0][ROB_IDX_BITS-1:0]  rob_tail_idx;
    logic [ROB_CNT_BITS-1:0]            rob_free_slots;
    RETIRE_PACKET [WAYS-1:0]            retire_out;
    logic                               squash_out;
    logic                               halt_out;

    int errors = 0;
    int checks = 0;

    rob_retire #(
        .ROB_DEPTH (32),
        .WAYS      (WAYS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_in    (dispatch_in),
        .complete_in    (complete_in),
        .rob_tail_idx   (rob_tail_idx),
        .rob_free_slots (rob_free_slots),
        .retire_out     (retire_out),
        .squash_out     (squash_out),
        .halt_out       (halt_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rp(input int ar, input int t, input int told);
        RETIRE_PACKET p;
        p.complete = 1'b1;
        p.ar_idx   = AR_IDX_BITS'(ar);
        p.t_idx    = PR_IDX_BITS'(t);
        p.told_idx = PR_IDX_BITS'(told);
        return 32'(p);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dispatch_in = '0;
        complete_in = '0;
    endtask

    task automatic disp(input int lane, input int ar, input int t, input int told, input logic h);
        dispatch_in[lane].valid    = 1'b1;
        dispatch_in[lane].ar_idx   = AR_IDX_BITS'(ar);
        dispatch_in[lane].t_idx    = PR_IDX_BITS'(t);
        dispatch_in[lane].told_idx = PR_IDX_BITS'(told);
        dispatch_in[lane].halt     = h;
    endtask

    task automatic comp(input int lane, input int idx, input logic mp);
        complete_in[lane].valid      = 1'b1;
        complete_in[lane].rob_idx    = ROB_IDX_BITS'(idx);
        complete_in[lane].mispredict = mp;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Starting from an empty ROB at slot 0, push n entries through and wait until drained.
    task automatic fill_and_drain(input int n);
        int left;
        int slot;
        left = n;
        while (left > 0) begin
            idle();
            for (int k = 0; k < 3 && left > 0; k++) begin
                disp(k, 0, 0, 0, 1'b0);
                left--;
            end
            step();
        end
        left = n;
        slot = 0;
        while (left > 0) begin
            idle();
            for (int k = 0; k < 3 && left > 0; k++) begin
                comp(k, slot, 1'b0);
                slot++;
                left--;
            end
            step();
        end
        idle();
        for (int i = 0; i < 20 && rob_free_slots != 32; i++) step();
        check("drain_free", 32'(rob_free_slots), 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b0;
        step();
        check("rst_free", 32'(rob_free_slots), 32);
        check("rst_ret0", 32'(retire_out[0]), 0);
        check("rst_ret1", 32'(retire_out[1]), 0);
        check("rst_ret2", 32'(retire_out[2]), 0);
        check("rst_squash", 32'(squash_out), 0);
        check("rst_halt", 32'(halt_out), 0);
        check("rst_tail0", 32'(rob_tail_idx[0]), 0);
        check("rst_tail1", 32'(rob_tail_idx[1]), 1);
        check("rst_tail2", 32'(rob_tail_idx[2]), 2);
        reset = 1'b1;
        step();

        // In-order retire
        disp(0, 1, 33, 17, 1'b0);
        disp(1, 2, 34, 18, 1'b0);
        disp(2, 3, 35, 19, 1'b0);
        step();
        check("io_free3", 32'(rob_free_slots), 29);
        check("io_tail", 32'(rob_tail_idx[0]), 3);
        idle();
        comp(0, 1, 1'b0);
        step();
        check("io_noret0", 32'(retire_out[0]), 0);
        check("io_noret1", 32'(retire_out[1]), 0);
        idle();
        comp(0, 0, 1'b0);
        step();
        check("io_ret0", 32'(retire_out[0]), rp(1, 33, 17));
        check("io_ret1", 32'(retire_out[1]), rp(2, 34, 18));
        check("io_ret2", 32'(retire_out[2]), 0);
        check("io_nocredit", 32'(rob_free_slots), 29);
        idle();
        step();
        check("io_free_after", 32'(rob_free_slots), 31);
        check("io_head", 32'(dut.r_head), 2);
        check("io_slot2_wait", 32'(retire_out[0]), 0);
        comp(0, 2, 1'b0);
        step();
        check("io_ret_slot2", 32'(retire_out[0]), rp(3, 35, 19));
        idle();
        step();
        check("io_free_empty", 32'(rob_free_slots), 32);

        // Reset mid-traffic
        disp(0, 4, 36, 20, 1'b0);
        disp(1, 5, 37, 21, 1'b0);
        disp(2, 6, 38, 22, 1'b0);
        step();
        idle();
        comp(0, 3, 1'b0);
        step();
        check("mr_pre_ret", 32'(retire_out[0]), rp(4, 36, 20));
        idle();
        reset = 1'b0;
        #1;
        check("mr_async_free", 32'(rob_free_slots), 32);
        check("mr_async_ret", 32'(retire_out[0]), 0);
        step();
        check("mr_free", 32'(rob_free_slots), 32);
        check("mr_squash", 32'(squash_out), 0);
        check("mr_tail", 32'(rob_tail_idx[0]), 0);
        reset = 1'b1;
        step();

        // Full
        for (int c = 0; c < 11; c++) begin
            idle();
            for (int k = 0; k < ((c < 10) ? 3 : 2); k++) disp(k, k, c, 0, 1'b0);
            step();
        end
        idle();
        check("full_free", 32'(rob_free_slots), 0);
        check("full_tail", 32'(rob_tail_idx[0]), 0);
        disp(0, 9, 9, 9, 1'b0);
        step();
        idle();
        check("full_drop_free", 32'(rob_free_slots), 0);
        check("full_drop_tail", 32'(rob_tail_idx[0]), 0);
        check("full_head", 32'(dut.r_head), 0);
        do_reset();

        // Wrap
        fill_and_drain(30);
        check("wrap_head30", 32'(dut.r_head), 30);
        check("wrap_tail30", 32'(rob_tail_idx[0]), 30);
        check("wrap_tail_lane2", 32'(rob_tail_idx[2]), 0);
        disp(0, 7, 40, 20, 1'b0);
        disp(1, 8, 41, 21, 1'b0);
        disp(2, 9, 42, 22, 1'b0);
        step();
        idle();
        check("wrap_tail1", 32'(rob_tail_idx[0]), 1);
        comp(0, 30, 1'b0);
        comp(1, 31, 1'b0);
        comp(2, 0, 1'b0);
        step();
        idle();
        check("wrap_ret0", 32'(retire_out[0]), rp(7, 40, 20));
        check("wrap_ret1", 32'(retire_out[1]), rp(8, 41, 21));
        check("wrap_ret2", 32'(retire_out[2]), rp(9, 42, 22));
        step();
        check("wrap_head1", 32'(dut.r_head), 1);
        check("wrap_free", 32'(rob_free_slots), 32);

        // Squash
        do_reset();
        fill_and_drain(5);
        disp(0, 10, 50, 1, 1'b0);
        disp(1, 11, 51, 2, 1'b0);
        disp(2, 12, 52, 3, 1'b0);
        step();
        idle();
        disp(0, 13, 53, 4, 1'b0);
        disp(1, 14, 54, 5, 1'b0);
        disp(2, 15, 55, 6, 1'b0);
        step();
        idle();
        comp(0, 5, 1'b0);
        comp(1, 6, 1'b1);
        comp(2, 7, 1'b0);
        step();
        idle();
        check("sq_ret0", 32'(retire_out[0]), rp(10, 50, 1));
        check("sq_ret1", 32'(retire_out[1]), rp(11, 51, 2));
        check("sq_ret2", 32'(retire_out[2]), 0);
        check("sq_flag", 32'(squash_out), 1);
        check("sq_free_pre", 32'(rob_free_slots), 26);
        // Inputs during the squash cycle must be ignored.
        disp(0, 20, 60, 7, 1'b0);
        comp(0, 8, 1'b0);
        step();
        idle();
        check("sq_free", 32'(rob_free_slots), 32);
        check("sq_head", 32'(dut.r_head), 7);
        check("sq_tail", 32'(rob_tail_idx[0]), 7);
        check("sq_flag_off", 32'(squash_out), 0);
        check("sq_noret", 32'(retire_out[0]), 0);
        comp(0, 8, 1'b0);
        step();
        idle();
        check("sq_stale_comp", 32'(retire_out[0]), 0);

        // Halt
        do_reset();
        disp(0, 1, 33, 0, 1'b1);
        disp(1, 2, 34, 0, 1'b0);
        step();
        idle();
        comp(0, 0, 1'b0);
        comp(1, 1, 1'b0);
        step();
        idle();
`ifdef ROB_HALT_RETIRE_EN
        check("halt_ret0", 32'(retire_out[0]), rp(1, 33, 0));
        check("halt_ret1", 32'(retire_out[1]), 0);
        check("halt_flag", 32'(halt_out), 1);
        step();
        check("halt_blocked", 32'(retire_out[0]), 0);
        check("halt_flag_off", 32'(halt_out), 0);
        check("halt_free", 32'(rob_free_slots), 31);
        step();
        check("halt_still_blocked", 32'(retire_out[0]), 0);
`else
        check("nohalt_ret0", 32'(retire_out[0]), rp(1, 33, 0));
        check("nohalt_ret1", 32'(retire_out[1]), rp(2, 34, 0));
        check("nohalt_flag", 32'(halt_out), 0);
        step();
        check("nohalt_free", 32'(rob_free_slots), 32);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer with in-order retirement. It is the producer of the `RETIRE_PACKET` stream that the architectural map table consumes. The block accepts up to `SUPERSCALAR_WAYS` dispatched instructions per cycle into a circular buffer and marks entries complete from CDB broadcasts. It retires up to `SUPERSCALAR_WAYS` oldest completed entries per cycle in program order, and triggers a full pipeline squash when a mispredicted branch retires.

## Interface
- `ROB_DEPTH`, default 32: number of entries; must be a power of 2.
- `WAYS`, default `` `SUPERSCALAR_WAYS `` (3): dispatch, complete and retire width.
- `clock  in  1`: single clock.
- `reset  in  1`: asynchronous, active-low reset.
- `dispatch_in  in  [WAYS] ROB_DISPATCH_PACKET`: fields `valid`, `ar_idx`, `t_idx`, `told_idx`, `halt`. Valid lanes are packed from lane 0, oldest in lane 0.
- `complete_in  in  [WAYS] ROB_COMPLETE_PACKET`: fields `valid`, `rob_idx`, `mispredict`.
- `rob_tail_idx  out  [WAYS][ROB_IDX_BITS]`: slot indices that this cycle's dispatch lanes will occupy.
- `rob_free_slots  out  ROB_CNT_BITS`: registered count of free entries.
- `retire_out  out  [WAYS] RETIRE_PACKET`: fields `complete`, `ar_idx`, `t_idx`, `told_idx`.
- `squash_out  out  1`: a mispredicted branch retires this cycle.
- `halt_out  out  1`: only with `ROB_HALT_RETIRE_EN`.

## Operation
- **State**:
  - `head`, `tail`: `ROB_IDX_BITS` each, wrapping modulo `ROB_DEPTH`.
  - `count`: 0..`ROB_DEPTH`.
  - Per entry: `valid`, `done`, `mispredict`, `ar_idx`, `t_idx`, `told_idx`, `halt`.
- **Dispatch**:
  - Lane k writes slot `tail+k` and sets `valid=1`, `done=0`.
  - `tail` advances by the number of valid lanes.
  - Upstream guarantees valid lanes ≤ `rob_free_slots`. Lanes beyond the free count are dropped, and a simulation assertion fires.
- **Complete**: each valid lane sets `done=1` and `mispredict` at `rob_idx`. A complete for an invalid entry is ignored.
- **Retire**:
  - Lane k is eligible if entry `head+k` is valid and done, and every lane j<k is eligible and has no `mispredict` set.
  - `retire_out[k].complete=1` for eligible lanes, carrying that entry's `ar_idx`, `t_idx` and `told_idx`.
  - Ineligible lanes output all zeros.
  - `head` advances by the retired count, and retired entries clear `valid`.
- **Squash**:
  - If the youngest retiring lane has `mispredict`, `squash_out=1` that cycle.
  - At the next edge: all entries clear `valid`, `head=tail=`(head+retired count), `count=0`.
  - Dispatch and complete inputs in the squash cycle are ignored.
- **Count update**: `count_next = count + dispatched − retired`, or 0 on squash. `rob_free_slots = ROB_DEPTH − count`.

## Timing
- **Reset** (async assert, released synchronously to `clock`): `head=tail=count=0`, all `valid=0`.
  - `retire_out` is all zeros, `squash_out=0`, `halt_out=0`, `rob_free_slots=ROB_DEPTH`.
  - `rob_tail_idx` = 0,1,2.
  - Reset mid-operation discards all entries immediately.
- `retire_out`, `squash_out` and `halt_out` are combinational from registered state only; there is no input-to-output path.
- **Latency**:
  - Dispatch at edge N → complete accepted at edge N+1 at the earliest.
  - Complete at edge N → `retire_out` valid during cycle N+1 → `head` advances at edge N+2.
- A complete and a retire to the same slot in one cycle cannot occur, because retire requires `done` already registered.
- `rob_free_slots` does not credit same-cycle retirements; freed slots are usable the following cycle.
- **Full**: `count==ROB_DEPTH` gives `rob_free_slots=0`, and dispatch is dropped. `head==tail` with `count` distinguishing full from empty.
- **Wrap**: slot indices wrap from `ROB_DEPTH−1` to 0 within a single dispatch or retire group.

## Configuration
- **`ROB_HALT_RETIRE_EN` defined**:
  - A retiring entry with `halt=1` is the last eligible lane, and lanes after it are suppressed.
  - `halt_out=1` that cycle, and a sticky halted flag blocks all later retirement until reset.
- **Undefined**: the `halt` field is stored but ignored, and `halt_out` is tied to 0.

## Structure
- Shared package holds:
  - `ROB_DISPATCH_PACKET`, `ROB_COMPLETE_PACKET` and `ROB_ENTRY` typedefs.
  - `ROB_IDX_BITS = $clog2(ROB_DEPTH)` and `ROB_CNT_BITS = $clog2(ROB_DEPTH+1)`.
  - `RETIRE_PACKET` already lives there; add `told_idx` to it.
- One sub-module, `rob_retire_select`: combinational eligibility chain that produces the per-lane retire mask, the retired count and the squash/halt flags.

## Test plan
- **Reset**: assert `reset=0` mid-traffic → next cycle `rob_free_slots=32`, all `retire_out.complete=0`, `squash_out=0`.
- **In-order retire**:
  - Dispatch 3 lanes (ar 1/2/3, t 33/34/35), complete slot 1 then slot 0.
  - Response: no retire after slot 1's complete.
  - The cycle after slot 0's complete, lanes 0 and 1 retire (ar 1 t 33, ar 2 t 34).
- **Full**: 32 dispatches without completes → `rob_free_slots=0`; a 33rd dispatch is dropped and `tail` is unchanged.
- **Wrap**: `head=tail=30`, dispatch 3, complete all → retire slots 30, 31, 0 in lanes 0..2; final `head=1`.
- **Squash**: slots 5, 6, 7 done, slot 6 `mispredict=1` → lanes 0 and 1 retire, `squash_out=1`, lane 2 zero; next cycle `count=0`, `head=tail=7`.
- **Halt** (with `ROB_HALT_RETIRE_EN`): slot 0 halt, slots 0 and 1 done → only lane 0 retires, `halt_out=1`; slot 1 never retires.
